// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : DEPTH-slice inter-stage pipeline register with ready/valid
//            backpressure, bubble collapsing and synchronous flush.
//            Optional performance counters under PIPE_STAGE_REG_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        occupancy
`ifdef PIPE_STAGE_REG_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       bubble_cnt
`endif
);

    localparam int unsigned c_LAST = DEPTH - 1;

    logic [DEPTH-1:0]  r_v;
    logic [CTRL_W-1:0] r_c [DEPTH];
    logic [DATA_W-1:0] r_d [DEPTH];

    logic [DEPTH-1:0]  w_adv;
    logic [DEPTH-1:0]  w_src_v;
    logic [CTRL_W-1:0] w_src_c [DEPTH];
    logic [DATA_W-1:0] w_src_d [DEPTH];
    logic [2:0]        w_occ;

    // A slice may advance when downstream takes the output or any slice at
    // or beyond it is empty, so bubbles are squeezed out even under stall.
    always_comb begin
        w_adv = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            w_adv[k] = out_ready;
            for (int j = k; j < int'(DEPTH); j++) begin
                if (!r_v[j]) begin
                    w_adv[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_src_v    = '0;
        w_src_v[0] = in_valid;
        w_src_c[0] = in_ctrl;
        w_src_d[0] = in_data;
        for (int k = 1; k < int'(DEPTH); k++) begin
            w_src_v[k] = r_v[k-1];
            w_src_c[k] = r_c[k-1];
            w_src_d[k] = r_d[k-1];
        end
    end

    always_comb begin
        w_occ = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            w_occ = w_occ + 3'(r_v[k]);
        end
    end

    // Control is zeroed whenever a slice empties so a bubble reads as a NOP;
    // data is left untouched on bubbles and flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                r_c[k] <= '0;
                r_d[k] <= '0;
            end
        end else if (flush) begin
            r_v <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                r_c[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (w_adv[k]) begin
                    r_v[k] <= w_src_v[k];
                    r_c[k] <= w_src_v[k] ? w_src_c[k] : '0;
                    if (w_src_v[k]) begin
                        r_d[k] <= w_src_d[k];
                    end
                end
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_v[c_LAST];
    assign out_ctrl  = r_c[c_LAST];
    assign out_data  = r_d[c_LAST];
    assign occupancy = w_occ;

`ifdef PIPE_STAGE_REG_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_bubble_cnt;

    // Both counters saturate rather than wrap; flush does not clear them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_v[c_LAST] && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (!r_v[c_LAST] && !flush && (r_bubble_cnt != 16'hFFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// Testbench for pipe_stage_reg: DEPTH 1..4 instances share one stimulus
// stream, each checked every cycle against a queue-of-positions model.
module tb_pipe_stage_reg;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_ctrl   = '0;
    logic [31:0] in_data   = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  c;
        logic [31:0] d;
        int          pos;
    } item_t;

    for (genvar gd = 1; gd <= 4; gd++) begin : g_p
        logic        w_in_ready;
        logic        w_out_valid;
        logic [7:0]  w_out_ctrl;
        logic [31:0] w_out_data;
        logic [2:0]  w_occ;
`ifdef PIPE_STAGE_REG_PERF_EN
        logic [15:0] w_stall;
        logic [15:0] w_bubble;
`endif
        item_t       q[$];
        logic [31:0] m_last = '0;

        pipe_stage_reg #(
            .DATA_W(32),
            .CTRL_W(8),
            .DEPTH (gd)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (w_in_ready),
            .in_ctrl   (in_ctrl),
            .in_data   (in_data),
            .out_valid (w_out_valid),
            .out_ready (out_ready),
            .out_ctrl  (w_out_ctrl),
            .out_data  (w_out_data),
            .occupancy (w_occ)
`ifdef PIPE_STAGE_REG_PERF_EN
            ,
            .stall_cnt (w_stall),
            .bubble_cnt(w_bubble)
`endif
        );

        // Items are an ordered list with slot positions; each moves up one
        // slot per cycle unless blocked by the item ahead of it.
        always @(posedge clk or negedge rst) begin : p_model
            int lim;
            int np;
            bit acc;
            if (!rst) begin
                q.delete();
                m_last = '0;
            end else begin
                acc = in_valid && ((q.size() < gd) || out_ready);
                if (out_ready && q.size() > 0) begin
                    if (q[0].pos == gd - 1) void'(q.pop_front());
                end
                if (flush) begin
                    q.delete();
                end else begin
                    lim = gd - 1;
                    for (int i = 0; i < q.size(); i++) begin
                        np = (q[i].pos + 1 < lim) ? q[i].pos + 1 : lim;
                        if (np == gd - 1 && q[i].pos != gd - 1) m_last = q[i].d;
                        q[i].pos = np;
                        lim = np - 1;
                    end
                    if (acc) begin
                        q.push_back('{c: in_ctrl, d: in_data, pos: 0});
                        if (gd == 1) m_last = in_data;
                    end
                end
            end
        end

        always @(negedge clk) begin : p_compare
            logic       exp_v;
            logic [7:0] exp_c;
            exp_v = 1'b0;
            exp_c = '0;
            if (q.size() > 0) begin
                if (q[0].pos == gd - 1) begin
                    exp_v = 1'b1;
                    exp_c = q[0].c;
                end
            end
            chk($sformatf("d%0d_in_ready", gd), 32'(w_in_ready),
                32'((q.size() < gd) || out_ready));
            chk($sformatf("d%0d_out_valid", gd), 32'(w_out_valid), 32'(exp_v));
            chk($sformatf("d%0d_out_ctrl", gd), 32'(w_out_ctrl), 32'(exp_c));
            chk($sformatf("d%0d_out_data", gd), w_out_data,
                exp_v ? q[0].d : m_last);
            chk($sformatf("d%0d_occupancy", gd), 32'(w_occ), 32'(q.size()));
        end
    end

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
    endtask

    initial begin
        // Reset state
        repeat (2) step();
        chk("rst_valid", 32'(g_p[3].w_out_valid), 32'd0);
        chk("rst_ctrl", 32'(g_p[3].w_out_ctrl), 32'd0);
        chk("rst_data", g_p[3].w_out_data, 32'd0);
        chk("rst_occ", 32'(g_p[3].w_occ), 32'd0);
        rst = 1'b1;

        // Streaming 1..10 with out_ready held high
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            in_valid = (cyc < 10);
            in_data  = 32'(cyc + 1);
            in_ctrl  = 8'(8'h10 + cyc);
            #1;
            if (cyc < 10) chk("stream_in_ready", 32'(g_p[2].w_in_ready), 32'd1);
            step();
            chk("stream_d2_valid", 32'(g_p[2].w_out_valid), 32'(cyc >= 1 && cyc <= 10));
            if (cyc >= 1 && cyc <= 10) chk("stream_d2_data", g_p[2].w_out_data, 32'(cyc));
            if (cyc < 10) chk("stream_d1_data", g_p[1].w_out_data, 32'(cyc + 1));
        end

        // Backpressure on DEPTH=3
        drain();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(11 + i);
            in_ctrl  = 8'(8'h30 + i);
            #1;
            chk("bp_in_ready", 32'(g_p[3].w_in_ready), 32'd1);
            step();
        end
        in_data = 32'd14;
        in_ctrl = 8'h33;
        #1;
        chk("bp_full_in_ready", 32'(g_p[3].w_in_ready), 32'd0);
        chk("bp_occ", 32'(g_p[3].w_occ), 32'd3);
        chk("bp_model_occ", 32'(g_p[3].q.size()), 32'd3);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(g_p[3].w_in_ready), 32'd1);
        chk("bp_head", g_p[3].w_out_data, 32'd11);
        step();
        in_valid = 1'b0;
        chk("bp_drain1", g_p[3].w_out_data, 32'd12);
        step();
        chk("bp_drain2", g_p[3].w_out_data, 32'd13);
        step();
        chk("bp_drain3", g_p[3].w_out_data, 32'd14);
        chk("bp_drain3_valid", 32'(g_p[3].w_out_valid), 32'd1);

        // Bubble collapse on DEPTH=3
        drain();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; in_ctrl = 8'h41;
        step();
        in_valid = 1'b0;
        step();
        in_valid = 1'b1; in_data = 32'hB; in_ctrl = 8'h42;
        step();
        in_valid = 1'b0;
        #1;
        chk("bub_occ", 32'(g_p[3].w_occ), 32'd2);
        step();
        out_ready = 1'b1;
        #1;
        chk("bub_head_data", g_p[3].w_out_data, 32'hA);
        chk("bub_head_ctrl", 32'(g_p[3].w_out_ctrl), 32'h41);
        step();
        chk("bub_next_valid", 32'(g_p[3].w_out_valid), 32'd1);
        chk("bub_next_data", g_p[3].w_out_data, 32'hB);
        chk("bub_next_ctrl", 32'(g_p[3].w_out_ctrl), 32'h42);

        // Flush on DEPTH=2
        drain();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'd21; in_ctrl = 8'h51;
        step();
        in_data = 32'd22; in_ctrl = 8'h52;
        step();
        in_valid = 1'b0;
        #1;
        chk("fl_occ_full", 32'(g_p[2].w_occ), 32'd2);
        out_ready = 1'b1; flush = 1'b1;
        in_valid = 1'b1; in_data = 32'd99; in_ctrl = 8'h99;
        #1;
        chk("fl_out_valid", 32'(g_p[2].w_out_valid), 32'd1);
        chk("fl_out_data", g_p[2].w_out_data, 32'd21);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_after_valid", 32'(g_p[2].w_out_valid), 32'd0);
        chk("fl_after_ctrl", 32'(g_p[2].w_out_ctrl), 32'd0);
        chk("fl_after_occ", 32'(g_p[2].w_occ), 32'd0);
        chk("fl_data_hold", g_p[2].w_out_data, 32'd21);
        repeat (3) step();
        chk("fl_no_ghost", 32'(g_p[2].w_out_valid), 32'd0);

        // Asynchronous reset mid-stream on DEPTH=3
        drain();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(32'h100 + i);
            in_ctrl  = 8'hA5;
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("ar_occ_full", 32'(g_p[3].w_occ), 32'd3);
        chk("ar_ctrl_full", 32'(g_p[3].w_out_ctrl), 32'hA5);
        rst = 1'b0;
        #1;
        chk("ar_valid", 32'(g_p[3].w_out_valid), 32'd0);
        chk("ar_ctrl", 32'(g_p[3].w_out_ctrl), 32'd0);
        chk("ar_data", g_p[3].w_out_data, 32'd0);
        chk("ar_occ", 32'(g_p[3].w_occ), 32'd0);
        step();
        rst = 1'b1;

        // Randomized traffic
        drain();
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_data   = $urandom;
            in_ctrl   = 8'($urandom);
            out_ready = ($urandom_range(9) < 6);
            flush     = ($urandom_range(19) == 0);
            step();
        end
        drain();

`ifdef PIPE_STAGE_REG_PERF_EN
        rst = 1'b0;
        step();
        rst = 1'b1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (5) step();
        chk("perf_bubble_d1", 32'(g_p[1].w_bubble), 32'd5);
        chk("perf_bubble_d2", 32'(g_p[2].w_bubble), 32'd5);
        chk("perf_bubble_d3", 32'(g_p[3].w_bubble), 32'd5);
        chk("perf_bubble_d4", 32'(g_p[4].w_bubble), 32'd5);
        in_valid = 1'b1; in_data = 32'h5A5A; in_ctrl = 8'h77;
        step();
        in_valid = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        chk("perf_stall_d1", 32'(g_p[1].w_stall), 32'hFFFF);
        chk("perf_stall_d3", 32'(g_p[3].w_stall), 32'hFFFF);
        chk("perf_stall_d4", 32'(g_p[4].w_stall), 32'hFFFF);
        repeat (10) step();
        chk("perf_stall_hold_d3", 32'(g_p[3].w_stall), 32'hFFFF);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
